// File: rtl/div_seq.sv
// div_seq: sequential restoring divider, one quotient bit per clock.
//
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous, active-high reset
//   start     operation request, accepted on a rising edge where ready=1
//   sign      1 = two's-complement operands, 0 = unsigned (sampled with start)
//   x, y      dividend / divisor (sampled with start)
//   ready     idle, able to accept start
//   done      one-cycle pulse: q/r/error updated this cycle
//   error     divide-by-zero flag of the last completed op
//   q, r      quotient / remainder of the last completed op
//   dbg_state current FSM state (IDLE=0, CALC=1, FIX=2)
//
// Handshake: an operation is transferred on a rising clock edge where
// start=1 and ready=1; start while ready=0 is ignored and operands are not
// looked at again after the accepting edge. done rises on the same edge that
// ready returns high, so a start held through the done cycle is taken at
// that cycle's closing edge.
module div_seq #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         sign,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         ready,
  output logic         done,
  output logic         error,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic [N:0]    rem;      // partial remainder, one bit wider than operands
  logic [N-1:0]  dvd;      // dividend magnitude, shifts out as quotient shifts in
  logic [N-1:0]  ay;       // divisor magnitude
  logic [N-1:0]  xraw;     // raw dividend, reported as remainder on divide-by-zero
  logic          sx, sy;   // operand signs (0 in unsigned mode)
  logic          zero;     // divisor was zero

  logic          accept;
  logic [N-1:0]  mag_x, mag_y;
  logic [N:0]    rem_sh, trial;
  logic [N-1:0]  q_fix, r_fix;

  assign ready     = (state == IDLE);
  assign accept    = start & ready;
  assign dbg_state = state;

  // Magnitudes of the incoming operands. The most-negative value maps to
  // 2^(N-1), which still fits the unsigned N-bit magnitude.
  always_comb begin
    mag_x = x;
    mag_y = y;
    if (sign && x[N-1]) mag_x = -x;
    if (sign && y[N-1]) mag_y = -y;
  end

  // One restoring step: shift the next dividend bit into the remainder and
  // try subtracting the divisor; a clear MSB of the trial means it fitted.
  assign rem_sh = {rem[N-1:0], dvd[N-1]};
  assign trial  = rem_sh - {1'b0, ay};

  // Sign correction applied when the result is published.
  always_comb begin
    q_fix = dvd;
    r_fix = rem[N-1:0];
    if (sx ^ sy) q_fix = -dvd;
    if (sx)      r_fix = -rem[N-1:0];
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) state_nx = (y == '0) ? FIX : CALC;
      end
      CALC: begin
        if (cnt == CW'(1)) state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Datapath and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      rem   <= '0;
      dvd   <= '0;
      ay    <= '0;
      xraw  <= '0;
      sx    <= 1'b0;
      sy    <= 1'b0;
      zero  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      q     <= '0;
      r     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt  <= CW'(N);
            rem  <= '0;
            dvd  <= mag_x;
            ay   <= mag_y;
            xraw <= x;
            sx   <= sign & x[N-1];
            sy   <= sign & y[N-1];
            zero <= (y == '0);
          end
        end
        CALC: begin
          if (!trial[N]) rem <= trial;
          else           rem <= rem_sh;
          dvd <= {dvd[N-2:0], ~trial[N]};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          done <= 1'b1;
          if (zero) begin
            q     <= '1;
            r     <= xraw;
            error <= 1'b1;
          end else begin
            q     <= q_fix;
            r     <= r_fix;
            error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
